sar_avg_fifo: RTL and testbench

SAR_AVG_FIFO -- requirements
Module: sar_avg_fifo

---
 rtl/sar_avg_fifo.sv | 107 ++++++++++
 tb/tb_sar_avg_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_avg_fifo.sv
// rtl/sar_avg_fifo.sv - SAR sample averager feeding a 4-entry first-word-fall-through result FIFO
module sar_avg_fifo (
    input  logic       clk,
    input  logic       rest,
    input  logic       done,
    input  logic [5:0] din,
    input  logic [1:0] avg_sel,
    input  logic       rd_ready,
    input  logic       clr_ovf,
    output logic       rd_valid,
    output logic [5:0] rd_data,
    output logic [2:0] level,
    output logic       full,
    output logic       ovf
);

    logic [8:0] acc;
    logic [2:0] wcnt;
    logic [1:0] wsel;

    logic [5:0] mem [4];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] cnt;
    logic       ovf_q;

    logic [1:0] cur_sel;
    logic [2:0] win_last;
    logic [8:0] sum;
    logic [8:0] shifted;
    logic [5:0] result;
    logic       complete;
    logic       pop;
    logic       drop;
    logic       wr_en;

    // A fresh window takes its size straight from avg_sel; later samples use the latched size.
    always_comb begin
        cur_sel = (wcnt == 3'd0) ? avg_sel : wsel;
        case (cur_sel)
            2'd0:    win_last = 3'd0;
            2'd1:    win_last = 3'd1;
            2'd2:    win_last = 3'd3;
            default: win_last = 3'd7;
        endcase
        sum      = acc + {3'b000, din};
        shifted  = sum >> cur_sel;
        result   = shifted[5:0];
        complete = done && (wcnt == win_last);
        pop      = (cnt != 3'd0) && rd_ready;
        drop     = complete && (cnt == 3'd4) && !pop;
        wr_en    = complete && !drop;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            acc  <= 9'd0;
            wcnt <= 3'd0;
            wsel <= 2'd0;
        end else if (done) begin
            if (wcnt == 3'd0)
                wsel <= avg_sel;
            if (complete) begin
                acc  <= 9'd0;
                wcnt <= 3'd0;
            end else begin
                acc  <= sum;
                wcnt <= wcnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            for (int i = 0; i < 4; i++)
                mem[i] <= 6'd0;
            wptr  <= 2'd0;
            rptr  <= 2'd0;
            cnt   <= 3'd0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= result;
                wptr      <= wptr + 2'd1;
            end
            if (pop)
                rptr <= rptr + 2'd1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            // A fresh overflow outranks a clear request on the same edge.
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign rd_valid = (cnt != 3'd0);
    assign rd_data  = mem[rptr];
    assign level    = cnt;
    assign full     = (cnt == 3'd4);
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_sar_avg_fifo.sv
// tb/tb_sar_avg_fifo.sv - randomized and directed bench for sar_avg_fifo against a queue-based model
module tb_sar_avg_fifo;

    logic       clk;
    logic       rest;
    logic       done;
    logic [5:0] din;
    logic [1:0] avg_sel;
    logic       rd_ready;
    logic       clr_ovf;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic [2:0] level;
    logic       full;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    int win[$];
    int win_n = 1;
    int fifo[$];
    bit m_ovf = 0;

    sar_avg_fifo dut (
        .clk      (clk),
        .rest     (rest),
        .done     (done),
        .din      (din),
        .avg_sel  (avg_sel),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level),
        .full     (full),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a window is a list of samples; its mean is sum/N once N samples have arrived.
    task automatic model_step();
        bit pop;
        bit push;
        bit over;
        int res;
        int s;
        if (rest) begin
            win.delete();
            fifo.delete();
            win_n = 1;
            m_ovf = 0;
            return;
        end
        pop  = (fifo.size() > 0) && rd_ready;
        push = 0;
        res  = 0;
        if (done) begin
            if (win.size() == 0)
                win_n = 1 << avg_sel;
            win.push_back(int'(din));
            if (win.size() == win_n) begin
                s = 0;
                foreach (win[i]) s += win[i];
                res  = s / win_n;
                push = 1;
                win.delete();
            end
        end
        over = push && (fifo.size() == 4) && !pop;
        if (pop)
            void'(fifo.pop_front());
        if (push && !over)
            fifo.push_back(res);
        if (over)
            m_ovf = 1;
        else if (clr_ovf)
            m_ovf = 0;
    endtask

    initial forever begin
        @(posedge clk or posedge rest);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("rd_valid", int'(rd_valid), (fifo.size() > 0) ? 1 : 0);
        chk("level", int'(level), fifo.size());
        chk("full", int'(full), (fifo.size() == 4) ? 1 : 0);
        chk("ovf", int'(ovf), int'(m_ovf));
        if (fifo.size() > 0)
            chk("rd_data", int'(rd_data), fifo[0]);
        else if (rest)
            chk("rd_data_rst", int'(rd_data), 0);
    end

    task automatic cyc(input logic d, input logic [5:0] x, input logic [1:0] s,
                       input logic r, input logic c);
        done     = d;
        din      = x;
        avg_sel  = s;
        rd_ready = r;
        clr_ovf  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b1);
        cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rest     = 1'b1;
        done     = 1'b0;
        din      = 6'd0;
        avg_sel  = 2'd0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_data", int'(rd_data), 0);
        rest = 1'b0;
        @(posedge clk);
        #1;

        // Single-sample pass-through, then popped.
        cyc(1'b1, 6'd37, 2'd0, 1'b1, 1'b0);
        chk("d29_valid", int'(rd_valid), 1);
        chk("d29_data", int'(rd_data), 37);
        cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0);
        chk("d29_empty", int'(rd_valid), 0);

        // Four-sample mean, truncated; avg_sel changes mid-window are ignored.
        cyc(1'b1, 6'd10, 2'd2, 1'b0, 1'b0);
        chk("d30_np1", int'(level), 0);
        cyc(1'b1, 6'd11, 2'd0, 1'b0, 1'b0);
        chk("d30_np2", int'(level), 0);
        cyc(1'b1, 6'd12, 2'd3, 1'b0, 1'b0);
        chk("d30_np3", int'(level), 0);
        cyc(1'b1, 6'd14, 2'd1, 1'b0, 1'b0);
        chk("d30_level", int'(level), 1);
        chk("d30_data", int'(rd_data), 11);
        idle_drain();

        // Eight full-scale samples.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 6'd63, 2'd3, 1'b0, 1'b0);
        chk("d31_level", int'(level), 1);
        chk("d31_data", int'(rd_data), 63);
        idle_drain();

        // Overflow with five unread results.
        for (int i = 1; i <= 5; i++)
            cyc(1'b1, 6'(i), 2'd0, 1'b0, 1'b0);
        chk("d32_level", int'(level), 4);
        chk("d32_full", int'(full), 1);
        chk("d32_ovf", int'(ovf), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("d32_order", int'(rd_data), i);
            cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0);
        end
        chk("d32_empty", int'(rd_valid), 0);
        cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b1);
        chk("d32_clr", int'(ovf), 0);

        // Push and pop together while full.
        for (int i = 11; i <= 14; i++)
            cyc(1'b1, 6'(i), 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 6'd50, 2'd0, 1'b1, 1'b0);
        chk("d33_level", int'(level), 4);
        chk("d33_ovf", int'(ovf), 0);
        chk("d33_head", int'(rd_data), 12);
        idle_drain();

        // Reset mid-window discards the partial sum; done on release counts.
        cyc(1'b1, 6'd7, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 6'd20, 2'd1, 1'b0, 1'b0);
        rest = 1'b1;
        #2;
        chk("d34_async_valid", int'(rd_valid), 0);
        chk("d34_async_level", int'(level), 0);
        chk("d34_async_data", int'(rd_data), 0);
        @(posedge clk);
        #1;
        rest = 1'b0;
        cyc(1'b1, 6'd40, 2'd1, 1'b0, 1'b0);
        chk("d34_np", int'(level), 0);
        cyc(1'b1, 6'd42, 2'd1, 1'b0, 1'b0);
        chk("d34_level", int'(level), 1);
        chk("d34_data", int'(rd_data), 41);
        idle_drain();

        // Randomized traffic with varying consumer pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 800; n++) begin
                rest = ($urandom_range(0, 199) == 0);
                cyc($urandom_range(0, 99) < 60, 6'($urandom_range(0, 63)),
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 99) < (ph * 25 + 10),
                    $urandom_range(0, 99) < 5);
            end
        end
        rest = 1'b0;
        idle_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
